sqrt_fp_iter: RTL

- Parametrised, iterative floating-point square-root / inverse-square-root unit; next generation of SQRT_Floating_Point.
- Configurable mantissa and exponent widths.
- Normalises denormal mantissas on capture.
- Computes a bit-exact truncated result using a digit-by-digit root followed by restoring division.
- Adds a ready handshake and NaN/Inf flags.
- Sits beside the datapath as a multi-cycle coprocessor started by single-cycle command pulses.

---
 rtl/sqrt_fp_iter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sqrt_fp_iter.sv
// Iterative floating-point square root / inverse square root with bit-exact truncated results.
// Latency: SQRT MANT_W+1 edges, INVSQRT 2*MANT_W+2 edges, special operands 1 edge (start edge to valid_o).
// Backpressure: none on the result; ready_o is low while busy and starts seen then are dropped, not queued.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   DoSqrt_i, DoInvSqrt_i         single-cycle start pulses (SQRT wins if both are high)
//   s_i, m_i, e_i                 operand: sign, mantissa (1 integer bit), signed exponent
//   ready_o                       idle, a start is accepted this cycle
//   valid_o                       one-cycle result strobe
//   s_o, m_o, e_o, nan_o, inf_o   result fields and flags, held until the next result or reset
module sqrt_fp_iter #(
    parameter int MANT_W     = 8,
    parameter int EXP_W      = 8,
    parameter int SIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DoSqrt_i,
    input  logic              DoInvSqrt_i,
    input  logic              s_i,
    input  logic [MANT_W-1:0] m_i,
    input  logic [EXP_W-1:0]  e_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic              s_o,
    output logic [MANT_W-1:0] m_o,
    output logic [EXP_W-1:0]  e_o,
    output logic              nan_o,
    output logic              inf_o
);

    localparam int LZW = $clog2(MANT_W) + 1;
    localparam int CW  = $clog2(MANT_W + 1) + 1;
    localparam int RW  = MANT_W + 2;     // root remainder never exceeds 2*root
    localparam int NW  = 2 * MANT_W;     // integer radicand R << (MANT_W-1)

    typedef enum logic [1:0] {IDLE, ROOT, DIV, DONE} state_t;
    state_t state;

    logic              mode_inv, sp_nan, sp_inf, sp_zero;
    logic [EXP_W-1:0]  e_half;
    logic [NW-1:0]     rad_sh;
    logic [RW-1:0]     rem_r;
    logic [MANT_W-1:0] root_q;
    logic [MANT_W-1:0] div_rem;
    logic [MANT_W-1:0] quot;
    logic [CW-1:0]     cnt;

    // Operand normalisation: leading-zero count, then make the exponent even.
    logic [LZW-1:0]    lz;
    logic [MANT_W-1:0] m_norm;
    logic [EXP_W:0]    e_norm;
    logic [MANT_W:0]   rad;
    always_comb begin
        lz = '0;
        for (int i = 0; i < MANT_W; i++) begin
            if (m_i[i]) lz = LZW'(MANT_W - 1 - i);
        end
        m_norm = m_i << lz;
        e_norm = {e_i[EXP_W-1], e_i} - (EXP_W+1)'(lz);
        rad    = e_norm[0] ? {m_norm, 1'b0} : {1'b0, m_norm};
    end

    // One digit of the restoring square root: bring down two radicand bits.
    logic [RW+1:0] r_shift, r_trial;
    logic [RW-1:0] r_diff;
    logic          r_ge;
    always_comb begin
        r_shift = {rem_r, rad_sh[NW-1 -: 2]};
        r_trial = {2'b00, root_q, 2'b01};
        r_ge    = r_shift >= r_trial;
        r_diff  = r_shift[RW-1:0] - r_trial[RW-1:0];
    end

    // One bit of restoring division of 2^(2*MANT_W-1) by the root; dividend low bits are zero.
    logic [MANT_W:0]   d_shift;
    logic [MANT_W-1:0] d_div;
    logic              d_ge;
    always_comb begin
        d_shift = {div_rem, 1'b0};
        d_ge    = d_shift >= {1'b0, root_q};
        d_div   = d_shift[MANT_W-1:0] - root_q;
    end

    // Result selection. floor(e/2) of the even-adjusted exponent is e_norm >>> 1,
    // and -(e/2)-1 is simply the bitwise complement.
    logic              one_q;
    logic              res_s, res_nan, res_inf;
    logic [MANT_W-1:0] res_m;
    logic [EXP_W-1:0]  res_e;
    always_comb begin
        one_q   = root_q == {1'b1, {(MANT_W-1){1'b0}}};
        res_s   = 1'b0;
        res_nan = 1'b0;
        res_inf = 1'b0;
        res_m   = '0;
        res_e   = '0;
        if (sp_nan) begin
            res_s   = 1'b1;
            res_nan = 1'b1;
        end else if (sp_inf) begin
            res_inf = 1'b1;
            res_m   = '1;
            res_e   = {1'b0, {(EXP_W-1){1'b1}}};
        end else if (sp_zero) begin
            res_m   = '0;
        end else if (!mode_inv) begin
            res_m   = root_q;
            res_e   = e_half;
        end else begin
            // A root of exactly 1.0 inverts to 1.0; anything else lands in (0.5,1) and is renormalised.
            res_m   = one_q ? root_q : quot;
            res_e   = one_q ? -e_half : ~e_half;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            s_o      <= 1'b0;
            m_o      <= '0;
            e_o      <= '0;
            nan_o    <= 1'b0;
            inf_o    <= 1'b0;
            mode_inv <= 1'b0;
            sp_nan   <= 1'b0;
            sp_inf   <= 1'b0;
            sp_zero  <= 1'b0;
            e_half   <= '0;
            rad_sh   <= '0;
            rem_r    <= '0;
            root_q   <= '0;
            div_rem  <= '0;
            quot     <= '0;
            cnt      <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready_o && (DoSqrt_i || DoInvSqrt_i)) begin
                        mode_inv <= !DoSqrt_i;
                        sp_nan   <= (SIGN_CHECK != 0) && s_i && (m_i != '0);
                        sp_zero  <= (m_i == '0);
                        sp_inf   <= (m_i == '0) && !DoSqrt_i;
                        e_half   <= e_norm[EXP_W:1];
                        rad_sh   <= {rad, {(MANT_W-1){1'b0}}};
                        rem_r    <= '0;
                        root_q   <= '0;
                        cnt      <= '0;
                        ready_o  <= 1'b0;
                        if ((m_i == '0) || ((SIGN_CHECK != 0) && s_i))
                            state <= DONE;
                        else
                            state <= ROOT;
                    end
                end
                ROOT: begin
                    rem_r  <= r_ge ? r_diff : r_shift[RW-1:0];
                    root_q <= {root_q[MANT_W-2:0], r_ge};
                    rad_sh <= rad_sh << 2;
                    if (cnt == CW'(MANT_W - 1)) begin
                        cnt <= '0;
                        if (mode_inv) begin
                            div_rem <= {2'b01, {(MANT_W-2){1'b0}}};
                            quot    <= '0;
                            state   <= DIV;
                        end else begin
                            state   <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    div_rem <= d_ge ? d_div : d_shift[MANT_W-1:0];
                    // The top quotient bit is set only for a root of 1.0, which bypasses quot.
                    quot    <= {quot[MANT_W-2:0], d_ge};
                    if (cnt == CW'(MANT_W)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    s_o     <= res_s;
                    m_o     <= res_m;
                    e_o     <= res_e;
                    nan_o   <= res_nan;
                    inf_o   <= res_inf;
                    valid_o <= 1'b1;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
